fpga_mini_project: RTL and testbench

//  Top level of the DE1-SoC scope demo: VGA 640x480@60Hz display of an oscilloscope screen
//  (graticule, two cursors, two synthetic traces), each overlay enabled by a slide switch.

---
 rtl/fpga_mini_project_pkg.sv | 40 ++++
 rtl/fpga_mini_project_vga_timing.sv | 58 +++++
 rtl/fpga_mini_project.sv | 95 +++++++++
 tb/tb_fpga_mini_project.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fpga_mini_project_pkg.sv
// fpga_mini_project_pkg: VGA timing defaults, overlay geometry and colours for the scope demo.
package fpga_mini_project_pkg;
    localparam int DEF_H_VIS = 640;
    localparam int DEF_H_FP = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP = 48;
    localparam int DEF_V_VIS = 480;
    localparam int DEF_V_FP = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP = 33;
    localparam int H_TOTAL = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int DEF_CURSOR_X = 320;
    localparam int DEF_CURSOR_Y = 240;
    localparam logic [9:0] SIG1_BASE = 10'd176;
    localparam logic [9:0] SIG2_HIGH = 10'd140;
    localparam logic [9:0] SIG2_LOW = 10'd340;
    localparam logic [7:0] SIG2_HALF = 8'd80;
    localparam logic [7:0] SIG2_LAST = 8'd159;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t COL_BLACK = '{r: 8'h00, g: 8'h00, b: 8'h00};
    localparam rgb_t COL_GRID = '{r: 8'h40, g: 8'h40, b: 8'h40};
    localparam rgb_t COL_SIG1 = '{r: 8'hFF, g: 8'hFF, b: 8'h00};
    localparam rgb_t COL_SIG2 = '{r: 8'h00, g: 8'hFF, b: 8'hFF};
    localparam rgb_t COL_CURX = '{r: 8'hFF, g: 8'h00, b: 8'h00};
    localparam rgb_t COL_CURY = '{r: 8'h00, g: 8'hFF, b: 8'h00};

    // Triangle of period 128 folded from the 7-bit phase: rising 0..63, then falling 63..0.
    function automatic logic [9:0] sig1_row(input logic [6:0] t);
        logic [5:0] ramp;
        ramp = t[6] ? ~t[5:0] : t[5:0];
        return SIG1_BASE + {3'b000, ramp, 1'b0};
    endfunction
endpackage

// File: rtl/fpga_mini_project_vga_timing.sv
// vga_timing: pixel-clock divider, raster counters, active-low syncs and visible flag.
module vga_timing
    import fpga_mini_project_pkg::*;
#(
    parameter int H_VIS = DEF_H_VIS,
    parameter int H_FP = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP = DEF_H_BP,
    parameter int V_VIS = DEF_V_VIS,
    parameter int V_FP = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP = DEF_V_BP
) (
    input  logic       clock,
    input  logic       reset,
    output logic       vclk,
    output logic       pix_en,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       hsync,
    output logic       vsync,
    output logic       visible,
    output logic       frame_end
);
    localparam logic [9:0] H_LAST = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HS_ON = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_OFF = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_ON = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_OFF = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [9:0] H_END = 10'(H_VIS);
    localparam logic [9:0] V_END = 10'(V_VIS);

    logic h_last, v_last;

    assign pix_en = vclk;
    assign h_last = hcount == H_LAST;
    assign v_last = vcount == V_LAST;
    assign frame_end = pix_en && h_last && v_last;
    assign hsync = !(hcount >= HS_ON && hcount < HS_OFF);
    assign vsync = !(vcount >= VS_ON && vcount < VS_OFF);
    assign visible = hcount < H_END && vcount < V_END;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vclk <= 1'b0;
            hcount <= '0;
            vcount <= '0;
        end else begin
            vclk <= ~vclk;
            if (pix_en) begin
                hcount <= h_last ? 10'd0 : hcount + 10'd1;
                if (h_last)
                    vcount <= v_last ? 10'd0 : vcount + 10'd1;
            end
        end
    end
endmodule

// File: rtl/fpga_mini_project.sv
// fpga_mini_project: oscilloscope-style VGA screen with graticule, cursors and two synthetic traces.
module fpga_mini_project
    import fpga_mini_project_pkg::*;
#(
    parameter int H_VIS = DEF_H_VIS,
    parameter int H_FP = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP = DEF_H_BP,
    parameter int V_VIS = DEF_V_VIS,
    parameter int V_FP = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP = DEF_V_BP,
    parameter int CURSOR_X = DEF_CURSOR_X,
    parameter int CURSOR_Y = DEF_CURSOR_Y
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       switch0,
    input  logic       switch1,
    input  logic       switch2,
    input  logic       switch3,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic [7:0] R,
    output logic [7:0] G,
    output logic [7:0] B,
    output logic       VClock
);
    localparam logic [9:0] X_LAST = 10'(H_VIS - 1);
    localparam logic [9:0] Y_LAST = 10'(V_VIS - 1);
    localparam logic [9:0] H_LAST = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] CUR_X = 10'(CURSOR_X);
    localparam logic [9:0] CUR_Y = 10'(CURSOR_Y);

    logic pix_en, hs, vs, visible, frame_end;
    logic [9:0] hcount, vcount, sig1_y;
    logic [3:0] sw_meta, sw;
    logic [6:0] frame;
    logic [7:0] phase;
    logic hit1, hit2, grid;
    rgb_t pix;

    vga_timing #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) timing (
        .clock(clock),
        .reset(reset),
        .vclk(VClock),
        .pix_en(pix_en),
        .hcount(hcount),
        .vcount(vcount),
        .hsync(hs),
        .vsync(vs),
        .visible(visible),
        .frame_end(frame_end)
    );

    // The square-wave phase counts x mod 160 alongside hcount instead of dividing.
    always_comb begin
        sig1_y = sig1_row(hcount[6:0] + frame);
        hit1 = sw[2] && (vcount == sig1_y || vcount == sig1_y + 10'd1);
        hit2 = sw[3] && (vcount == (phase < SIG2_HALF ? SIG2_HIGH : SIG2_LOW) ||
               ((phase == 8'd0 || phase == SIG2_HALF) && vcount >= SIG2_HIGH && vcount <= SIG2_LOW));
        grid = hcount[5:0] == 6'd0 || vcount % 10'd48 == 10'd0 || hcount == X_LAST || vcount == Y_LAST;
        pix = !visible ? COL_BLACK :
              hit1 ? COL_SIG1 :
              hit2 ? COL_SIG2 :
              (sw[0] && hcount == CUR_X) ? COL_CURX :
              (sw[1] && vcount == CUR_Y) ? COL_CURY :
              grid ? COL_GRID : COL_BLACK;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sw_meta <= '0;
            sw <= '0;
            frame <= '0;
            phase <= '0;
            vga_hsync <= 1'b1;
            vga_vsync <= 1'b1;
            {R, G, B} <= '0;
        end else begin
            sw_meta <= {switch3, switch2, switch1, switch0};
            sw <= sw_meta;
            if (pix_en) begin
                frame <= frame_end ? frame + 7'd1 : frame;
                phase <= (hcount == H_LAST || phase == SIG2_LAST) ? 8'd0 : phase + 8'd1;
                vga_hsync <= hs;
                vga_vsync <= vs;
                {R, G, B} <= pix;
            end
        end
    end
endmodule

// File: tb/tb_fpga_mini_project.sv
// tb_fpga_mini_project: scoreboard bench; a shrunken raster instance is checked pixel by pixel, a default one for line timing.
`timescale 1ns/1ps
module tb_fpga_mini_project;
    localparam int HV = 64, HF = 2, HS = 4, HB = 2, HT = HV + HF + HS + HB;
    localparam int VV = 200, VF = 2, VS = 2, VB = 2, VT = VV + VF + VS + VB;
    localparam int CX = 20, CY = 100;

    typedef struct {
        int x;
        int y;
        int f;
        logic [25:0] v;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [3:0] sw = 4'd0;
    logic hs, vs, vclk, hs_d, vs_d, vclk_d;
    logic [7:0] r, g, b, r_d, g_d, b_d;
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit armed = 1'b0;
    exp_t q[$];

    always #10 clock = ~clock;

    fpga_mini_project #(
        .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CURSOR_X(CX), .CURSOR_Y(CY)
    ) dut (
        .clock(clock), .reset(reset),
        .switch0(sw[0]), .switch1(sw[1]), .switch2(sw[2]), .switch3(sw[3]),
        .vga_hsync(hs), .vga_vsync(vs), .R(r), .G(g), .B(b), .VClock(vclk)
    );

    fpga_mini_project ref_dut (
        .clock(clock), .reset(reset),
        .switch0(sw[0]), .switch1(sw[1]), .switch2(sw[2]), .switch3(sw[3]),
        .vga_hsync(hs_d), .vga_vsync(vs_d), .R(r_d), .G(g_d), .B(b_d), .VClock(vclk_d)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Screen content straight from the layer rules, evaluated per coordinate.
    function automatic logic [23:0] model_rgb(input int x, input int y, input int f, input logic [3:0] s);
        int t, ramp, y1, p, lvl;
        if (x >= HV || y >= VV) return 24'h000000;
        t = (x + f) % 128;
        ramp = t < 64 ? t : 127 - t;
        y1 = 176 + 2 * ramp;
        if (s[2] && (y == y1 || y == y1 + 1)) return 24'hFFFF00;
        p = x % 160;
        lvl = p < 80 ? 140 : 340;
        if (s[3] && (y == lvl || ((p == 0 || p == 80) && y >= 140 && y <= 340))) return 24'h00FFFF;
        if (s[0] && x == CX) return 24'hFF0000;
        if (s[1] && y == CY) return 24'h00FF00;
        if (x % 64 == 0 || y % 48 == 0 || x == HV - 1 || y == VV - 1) return 24'h404040;
        return 24'h000000;
    endfunction

    function automatic void push_line(input int l, input logic [3:0] s);
        exp_t e;
        int y, f;
        y = l % VT;
        f = (l / VT) % 128;
        for (int x = 0; x < HT; x++) begin
            e.x = x;
            e.y = y;
            e.f = f;
            e.v = {!(x >= HV + HF && x < HV + HF + HS), !(y >= VV + VF && y < VV + VF + VS), model_rgb(x, y, f, s)};
            q.push_back(e);
        end
    endfunction

    // Releases reset and streams n lines; switches change only in horizontal blanking.
    task automatic run(input int n);
        logic [3:0] s;
        int k;
        s = 4'($urandom);
        sw = s;
        push_line(0, s);
        armed = 1'b1;
        @(negedge clock);
        #1 reset = 1'b0;
        for (int l = 0; l < n; l++) begin
            while (cyc < 2 * (l * HT + HV + 1)) @(negedge clock);
            if (l < n - 1) begin
                s = 4'($urandom);
                sw = s;
                push_line(l + 1, s);
            end
        end
        k = 0;
        while (q.size() != 0 && k < 8 * HT) begin
            @(posedge clock);
            k++;
        end
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d pixels still expected, required 0", q.size());
        end
        armed = 1'b0;
    endtask

    initial forever begin
        @(posedge clock);
        cyc = reset ? 0 : cyc + 1;
    end

    initial forever begin
        exp_t e;
        @(negedge clock);
        if (armed && !reset && vclk == 1'b0) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL underflow: pixel presented with no expectation queued");
            end else begin
                e = q.pop_front();
                if ({hs, vs, r, g, b} !== e.v) begin
                    fails++;
                    $display("FAIL pixel (%0d,%0d) frame %0d: got hs/vs/rgb %h, required %h",
                             e.x, e.y, e.f, {hs, vs, r, g, b}, e.v);
                end
            end
        end
    end

    task automatic wait_sig(input int which, input logic lvl, output longint t);
        int n;
        n = 0;
        while ((which == 0 ? vclk_d : hs_d) !== lvl && n < 5000) begin
            @(negedge clock);
            n++;
        end
        t = $time;
        if (n >= 5000) begin
            tests++;
            fails++;
            $display("FAIL timeout: signal %0d never reached %b", which, lvl);
        end
    endtask

    initial begin : full_timing
        longint t0, t1, tf0, tr, tf1;
        @(negedge reset);
        wait_sig(0, 1'b1, t0);
        wait_sig(0, 1'b0, t1);
        wait_sig(0, 1'b1, t1);
        check("vclock_period_ns", 32'(t1 - t0), 32'd40);
        wait_sig(1, 1'b0, tf0);
        wait_sig(1, 1'b1, tr);
        check("hsync_low_ns", 32'(tr - tf0), 32'd3840);
        wait_sig(1, 1'b0, tf1);
        check("line_period_ns", 32'(tf1 - tf0), 32'd32000);
    end

    initial begin
        repeat (4) @(negedge clock);
        check("rst_vclock", {31'd0, vclk}, 32'd0);
        check("rst_syncs", {30'd0, hs, vs}, 32'd3);
        check("rst_rgb", {8'd0, r, g, b}, 32'd0);
        check("rst_vclock_full", {31'd0, vclk_d}, 32'd0);
        check("rst_syncs_full", {30'd0, hs_d, vs_d}, 32'd3);
        check("rst_rgb_full", {8'd0, r_d, g_d, b_d}, 32'd0);
        run(2 * VT + 10);
        repeat ($urandom_range(50, 100)) @(negedge clock);
        #1 reset = 1'b1;
        #2;
        check("midrst_vclock", {31'd0, vclk}, 32'd0);
        check("midrst_syncs", {30'd0, hs, vs}, 32'd3);
        check("midrst_rgb", {8'd0, r, g, b}, 32'd0);
        q.delete();
        repeat (3) @(negedge clock);
        run(20);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
